// File: rtl/cs_sched_pkg.sv
// rtl/cs_sched_pkg.sv - state encodings and sizing helpers shared by the chip-select write scheduler
package cs_sched_pkg;

   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] ST_INIT   = 3'd0;
   localparam logic [STATE_W-1:0] ST_ENABLE = 3'd1;
   localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd3;
   localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
   localparam logic [STATE_W-1:0] ST_BUSY   = 3'd5;

   // One counter is shared by INIT, SETTLE and the BUSY watchdog, so it is sized for the largest.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/cs_rr_arbiter.sv
// rtl/cs_rr_arbiter.sv - combinational round-robin pick: first asserted request at or above ptr_i, wrapping
module cs_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      pick_o  = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!valid_o && req_i[cand]) begin
            pick_o[cand] = 1'b1;
            idx_o        = cand;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cs_write_scheduler.sv
// rtl/cs_write_scheduler.sv - brings one chip-select peripheral out of reset and round-robins writes to it
// Define CS_TIMEOUT_EN to add the BUSY watchdog (err_timeout pulse, peripheral re-initialised on expiry).
module cs_write_scheduler
   import cs_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int RST_HOLD    = 5,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clk_4,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      flag_cs,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      rst_cs,
   output logic                      clk_cs,
   output logic                      we_cs,
   output logic [DATA_W-1:0]         wdata_cs,
   output logic [STATE_W-1:0]        state_o,
   output logic                      err_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(RST_HOLD, SETTLE_CYC, TIMEOUT_CYC);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rst_cs_q, rst_cs_d;
   logic               clk_en_q, clk_en_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               first_q, first_d;
   logic               tmo;

   logic [NUM_REQ-1:0] arb_pick;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   cs_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .pick_o  (arb_pick),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rst_cs_d = rst_cs_q;
      clk_en_d = clk_en_q;
      wdata_d  = wdata_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      first_d  = 1'b0;
      gnt      = '0;
      done     = '0;
      tmo      = 1'b0;
      case (state_q)
         ST_INIT: begin
            rst_cs_d = 1'b1;
            clk_en_d = 1'b0;
            if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
               state_d  = ST_ENABLE;
               cnt_d    = '0;
               rst_cs_d = 1'b0;
               clk_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ENABLE: state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (arb_valid) begin
               gnt     = arb_pick;
               wdata_d = DATA_W'(req_data >> (arb_idx * DATA_W));
               ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
               owner_d = arb_idx;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            first_d = 1'b1;
         end
         ST_BUSY: begin
            // first_q marks the mandatory dwell cycle, where flag_cs is not yet trusted
`ifdef CS_TIMEOUT_EN
            if (flag_cs) begin
               if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  tmo      = 1'b1;
                  state_d  = ST_INIT;
                  cnt_d    = '0;
                  rst_cs_d = 1'b1;
                  clk_en_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (!first_q) begin
               done[owner_q] = 1'b1;
               state_d       = ST_IDLE;
            end
`else
            if (!first_q && !flag_cs) begin
               done[owner_q] = 1'b1;
               state_d       = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d  = ST_INIT;
            cnt_d    = '0;
            rst_cs_d = 1'b1;
            clk_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         rst_cs_q <= 1'b1;
         clk_en_q <= 1'b0;
         wdata_q  <= '0;
         ptr_q    <= '0;
         owner_q  <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rst_cs_q <= rst_cs_d;
         clk_en_q <= clk_en_d;
         wdata_q  <= wdata_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         first_q  <= first_d;
      end
   end

   assign rst_cs      = rst_cs_q;
   assign clk_cs      = clk_4 & clk_en_q;
   assign we_cs       = (state_q == ST_WRITE);
   assign wdata_cs    = wdata_q;
   assign state_o     = state_q;
   assign err_timeout = tmo;

endmodule

// File: tb/tb_cs_write_scheduler.sv
// tb/tb_cs_write_scheduler.sv - randomized scoreboard bench for cs_write_scheduler
module tb_cs_write_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int RH  = 5;
   localparam int SC  = 4;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              clk_4 = 1'b0;
   logic              rst = 1'b0;
   logic              flag_cs;
   logic [NR-1:0]     req = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     gnt;
   logic [NR-1:0]     done;
   logic              rst_cs;
   logic              clk_cs;
   logic              we_cs;
   logic [DW-1:0]     wdata_cs;
   logic [2:0]        state_o;
   logic              err_timeout;

   cs_write_scheduler #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .RST_HOLD    (RH),
      .SETTLE_CYC  (SC),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_4       (clk_4),
      .req         (req),
      .req_data    (req_data),
      .flag_cs     (flag_cs),
      .gnt         (gnt),
      .done        (done),
      .rst_cs      (rst_cs),
      .clk_cs      (clk_cs),
      .we_cs       (we_cs),
      .wdata_cs    (wdata_cs),
      .state_o     (state_o),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;
   always #20 clk_4 = ~clk_4;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } gexp_t;

   gexp_t         exp_gnt_q[$];
   int            exp_done_q[$];
   int            exp_err_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            outstanding = 0;
   int            err_seen = 0;
   int            force_k = 0;
   int            mptr = 0;
   int            pend_we = -1;
   int            cur_owner = 0;
   logic [DW-1:0] pend_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // one clock of requester behaviour: a granted requester drops its req
   task automatic step();
      logic [NR-1:0] g;
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      req = req & ~g;
   endtask

   function automatic logic [NR*DW-1:0] rand_data();
      logic [NR*DW-1:0] d;
      d = '0;
      for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   // reference arbitration: set bits served in circular order starting at the model pointer
   task automatic issue_batch(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data);
      gexp_t ge;
      int    j;
      int    last;
      last = mptr;
      for (int k = 0; k < NR; k++) begin
         j = (mptr + k) % NR;
         if (mask[j]) begin
            ge.idx  = j;
            ge.data = data[j*DW +: DW];
            exp_gnt_q.push_back(ge);
            last = j;
         end
      end
      mptr     = (last + 1) % NR;
      req_data = data;
      req      = mask;
   endtask

   task automatic wait_batch(input string name);
      int b;
      b = 0;
      while ((exp_gnt_q.size() != 0 || outstanding != 0) && b < 300) begin
         step();
         b++;
      end
      if (b >= 300) begin
         bound_fail(name);
         exp_gnt_q.delete();
         outstanding = 0;
         req = '0;
      end
      step();
      step();
   endtask

   // n counts cycles from the first INIT cycle after reset release or watchdog expiry
   task automatic bringup_check();
      logic [NR-1:0] g;
      int            es;
      for (int n = 0; n <= RH + SC + 1; n++) begin
         @(negedge clk);
         if (n < RH) es = 0;
         else if (n == RH) es = 1;
         else if (n <= RH + SC) es = 2;
         else es = 3;
         chk("bringup_state", state_o, es);
         chk("bringup_rst_cs", rst_cs, (n < RH) ? 1 : 0);
         chk("bringup_clk_cs", clk_cs, (n >= RH) ? clk_4 : 1'b0);
         g = gnt;
         @(posedge clk);
         #1;
         req = req & ~g;
      end
   endtask

   initial begin : monitor
      gexp_t ge;
      int    ec;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (gnt != '0) begin
               if (exp_gnt_q.size() == 0) chk("gnt_unexpected", gnt, 0);
               else begin
                  ge = exp_gnt_q.pop_front();
                  chk("gnt", gnt, 64'(1) << ge.idx);
                  pend_we   = cyc + 1;
                  pend_data = ge.data;
                  cur_owner = ge.idx;
                  outstanding++;
               end
            end
            if (we_cs) begin
               chk("we_cs_cycle", cyc, pend_we);
               chk("wdata_cs", wdata_cs, pend_data);
            end
            if (done != '0) begin
               if (exp_done_q.size() == 0) chk("done_unexpected", done, 0);
               else begin
                  ec = exp_done_q.pop_front();
                  chk("done", done, 64'(1) << cur_owner);
                  chk("done_cycle", cyc, ec);
                  outstanding--;
               end
            end
            if (err_timeout) begin
               if (exp_err_q.size() == 0) chk("err_timeout_unexpected", err_timeout, 0);
               else begin
                  ec = exp_err_q.pop_front();
                  chk("err_timeout_cycle", cyc, ec);
                  err_seen++;
               end
            end
         end
      end
   end

   // peripheral: busy for k cycles after each write strobe
   initial begin : periph
      int k;
      int w;
      flag_cs = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && we_cs) begin
            w = cyc;
            k = (force_k > 0) ? force_k : int'($urandom_range(4));
`ifdef CS_TIMEOUT_EN
            if (k >= TMO) exp_err_q.push_back(w + TMO);
            else
`endif
            exp_done_q.push_back((k + 1 > 2) ? w + k + 1 : w + 2);
            @(posedge clk);
            #1;
            if (k > 0) begin
               flag_cs = 1'b1;
               repeat (k) @(posedge clk);
               #1;
               flag_cs = 1'b0;
            end
         end
      end
   end

   initial begin : driver
      logic [NR*DW-1:0] d;
      logic [NR-1:0]    m;
      int               b;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", state_o, 0);
      chk("reset_rst_cs", rst_cs, 1);
      chk("reset_clk_cs", clk_cs, 0);
      chk("reset_gnt", gnt, 0);
      chk("reset_done", done, 0);
      chk("reset_we_cs", we_cs, 0);
      chk("reset_wdata_cs", wdata_cs, 0);
      chk("reset_err_timeout", err_timeout, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bringup_check();

      issue_batch(4'b1111, rand_data());
      wait_batch("batch_1111");
      d = rand_data();
      d[2*DW +: DW] = 8'hA5;
      issue_batch(4'b0100, d);
      wait_batch("batch_0100");
      issue_batch(4'b0001, rand_data());
      wait_batch("batch_0001");
      issue_batch(4'b1001, rand_data());
      wait_batch("batch_1001");

      for (int r = 0; r < 20; r++) begin
         m = NR'($urandom_range((1 << NR) - 1, 1));
         issue_batch(m, rand_data());
         wait_batch("batch_random");
      end

      force_k = 6;
      issue_batch(NR'(1) << $urandom_range(NR - 1), rand_data());
      b = 0;
      while (outstanding == 0 && b < 50) begin
         step();
         b++;
      end
      if (b >= 50) bound_fail("midop_gnt_wait");
      step();
      #2 rst = 1'b0;
      #1;
      chk("midop_state", state_o, 0);
      chk("midop_rst_cs", rst_cs, 1);
      chk("midop_clk_cs", clk_cs, 0);
      chk("midop_gnt", gnt, 0);
      chk("midop_done", done, 0);
      chk("midop_we_cs", we_cs, 0);
      repeat (3) @(posedge clk);
      exp_done_q.delete();
      exp_gnt_q.delete();
      outstanding = 0;
      mptr        = 0;
      force_k     = 0;
      req         = '0;
      issue_batch(NR'($urandom_range((1 << NR) - 1, 1)), rand_data());
      #1;
      rst = 1'b1;
      bringup_check();
      wait_batch("batch_after_reset");

`ifdef CS_TIMEOUT_EN
      force_k  = TMO + 4;
      err_seen = 0;
      issue_batch(NR'(1) << $urandom_range(NR - 1), rand_data());
      b = 0;
      while (err_seen == 0 && b < 100) begin
         step();
         b++;
      end
      if (b >= 100) bound_fail("timeout_wait");
      outstanding = 0;
      force_k     = 0;
      bringup_check();
      issue_batch(NR'($urandom_range((1 << NR) - 1, 1)), rand_data());
      wait_batch("batch_after_timeout");
`else
      force_k = TMO + 4;
      issue_batch(NR'(1) << $urandom_range(NR - 1), rand_data());
      wait_batch("batch_long_busy");
      force_k = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/cs_write_scheduler.md
Name: cs_write_scheduler

Overview:
- Sequences one chip-select peripheral and shares its write port between NUM_REQ requesters.
- Brings the peripheral out of reset: holds rst_cs for RST_HOLD cycles, enables the gated clock, then waits SETTLE_CYC cycles.
- After bring-up, grants one write at a time by round-robin and waits for the peripheral busy flag (flag_cs) to clear before the next grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, write data width
- RST_HOLD, 5, cycles rst_cs is held high in INIT (>=1)
- SETTLE_CYC, 4, cycles waited after clock enable before the first grant (>=1)
- TIMEOUT_CYC, 64, BUSY watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- clk_4  in  1  divided clock to be gated toward the peripheral
- req  in  NUM_REQ  per-requester write request; level, held until gnt
- req_data  in  NUM_REQ*DATA_W  packed write data; slice i belongs to req[i]
- flag_cs  in  1  peripheral busy, synchronous to clk
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse when a request is accepted
- done  out  NUM_REQ  one-hot, 1-cycle pulse when the granted write completes
- rst_cs  out  1  peripheral reset, active-high
- clk_cs  out  1  clk_4 AND clk_en (clk_en is a register)
- we_cs  out  1  peripheral write strobe, 1 cycle
- wdata_cs  out  DATA_W  registered write data
- state_o  out  3  current state encoding
- err_timeout  out  1  watchdog pulse; tied 0 without the optional feature

Behaviour:
- Reset values (rst low, applied asynchronously): state=INIT, rst_cs=1, clk_en=0, we_cs=0, wdata_cs=0, gnt=0, done=0, rr pointer=0, counters=0, err_timeout=0.
- States and encodings: INIT=0, ENABLE=1, SETTLE=2, IDLE=3, WRITE=4, BUSY=5. Codes 6 and 7 go to INIT on the next clk.
- INIT:
  - rst_cs=1, clk_en=0.
  - Count RST_HOLD cycles after rst deasserts, then go to ENABLE.
- ENABLE:
  - 1 cycle. Set rst_cs=0 and clk_en=1.
  - Go to SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles, then go to IDLE.
  - Any req during INIT, ENABLE or SETTLE waits; none is dropped.
- IDLE, no req: stay in IDLE.
- IDLE, any req:
  - Pick the first asserted index at or above the rr pointer, wrapping at NUM_REQ.
  - That cycle: pulse gnt[i], latch req_data slice i into wdata_cs, set pointer=(i+1) mod NUM_REQ, remember i as owner.
  - Go to WRITE.
- WRITE: we_cs=1 for exactly 1 cycle, then go to BUSY.
- BUSY:
  - The first cycle ignores flag_cs (minimum dwell of 1 cycle).
  - After that, the first cycle with flag_cs==0 pulses done[owner] and goes to IDLE.
  - Without the optional feature, BUSY has no timeout.
- Latency:
  - req sampled in IDLE -> gnt in the same cycle.
  - we_cs 1 cycle after gnt.
  - done at least 2 cycles after we_cs.
  - Earliest next gnt is the cycle after done.
- Requester rules:
  - The requester deasserts req after seeing gnt.
  - req still high in the cycle after done counts as a new request.
  - req dropped before gnt is simply not served.
- Fairness: with all req held high, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: any state returns to INIT asynchronously. done is not pulsed for an aborted write, and the owner must re-request.
- Widths: counters are $clog2(max(RST_HOLD, SETTLE_CYC, TIMEOUT_CYC)+1) bits. Comparisons are equality against parameter-1, with no wrap.

Optional Feature:
- Macro CS_TIMEOUT_EN.
- Defined:
  - BUSY counts cycles while flag_cs==1.
  - Reaching TIMEOUT_CYC pulses err_timeout for 1 cycle, pulses no done, and goes to INIT, which re-resets the peripheral with rst_cs=1 and clk_en=0.
  - The rr pointer is kept.
- Undefined: no watchdog counter, err_timeout=0, BUSY waits indefinitely.

Decomposition:
- Package cs_sched_pkg holds:
  - the state encodings as localparams/typedef (INIT..BUSY, 3 bits)
  - state_o width (3)
  - a function computing counter width
- One sub-module, cs_rr_arbiter:
  - Combinational: takes req and pointer, returns a one-hot pick and its index.
  - The pointer register lives in the parent.

Test Plan:
- rst low 3 cycles, then high -> rst_cs=1 for exactly 5 clk, clk_en rises on the ENABLE cycle, state reaches IDLE 4 cycles later; clk_cs toggles with clk_4 only after ENABLE.
- req=4'b0100 with data 0xA5 in IDLE -> gnt=4'b0100, next cycle we_cs=1 and wdata_cs=0xA5. With flag_cs high 3 cycles then low -> done=4'b0100 once, state returns to IDLE.
- req=4'b1111 held, each write's flag_cs low after 2 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001.
- req=4'b1001 with pointer=1 -> grant index 3 first, then index 0.
- rst pulsed low while in BUSY -> asynchronous return to INIT with rst_cs=1, clk_en=0, gnt=0, done=0 and no done pulse; bring-up sequence repeats.
- CS_TIMEOUT_EN defined, TIMEOUT_CYC=8, flag_cs stuck at 1 -> err_timeout pulses 8 cycles into BUSY, state goes to INIT, rst_cs=1, no done.
